// File: rtl/board_block_reader.sv
// board_block_reader: reader side of the MIO_BUS board-tile port.
// Walks BlockID over the 16 tiles, captures each returned BlockType into a
// shadow register and commits the whole board atomically, so the display and
// game-status consumers never observe a half-updated snapshot.
//
// Optional build macro: BOARD_STATS_EN
//   defined   -> max_type / empty_cnt / win are accumulated during the scan
//                and published together with the board in the DONE cycle.
//   undefined -> no accumulators are built; the three stats outputs are 0.

module board_block_reader #(
    parameter int READ_LAT = 1,   // cycles from a BlockID change to valid BlockType (0..7)
    parameter int WIN_TYPE = 11   // tile exponent counted as a win (11 = tile 2048)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        auto_en,
    output logic [3:0]  BlockID,
    input  logic [3:0]  BlockType,
    output logic [63:0] board,
    output logic        board_valid,
    output logic        done,
    output logic        changed,
    output logic        busy,
    output logic [3:0]  max_type,
    output logic [4:0]  empty_cnt,
    output logic        win
);

    // Reject configurations the 3-bit wait counter or 4-bit tile values
    // cannot represent.
    if (READ_LAT < 0 || READ_LAT > 7 || WIN_TYPE < 0 || WIN_TYPE > 15) begin : g_bad_param
        $error("board_block_reader: READ_LAT must be 0..7 and WIN_TYPE 0..15");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [2:0]  wait_cnt;
    logic [63:0] shadow;
    logic [63:0] next_shadow;

    // Shadow image with the tile being captured this cycle merged in; used
    // both to update the shadow and to commit the last tile of a scan in the
    // same edge that enters DONE.
    always_comb begin
        // NOTE: assign the full default before the partial update so no latch is inferred.
        next_shadow                = shadow;
        next_shadow[idx * 4 +: 4] = BlockType;
    end

    // Scan sequencer with registered bus and commit outputs.
    // BlockID is loaded on the edge that enters ISSUE, so it is already stable
    // in ISSUE and holds through WAIT and CAPTURE of the same tile.
    // The commit happens on the edge entering DONE, so done, changed, board and
    // the stats are all visible together during the single DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 4'd0;
            BlockID     <= 4'd0;
            wait_cnt    <= 3'd0;
            // NOTE: shadow is a plain register vector, so it is reset to drop any partial scan.
            shadow      <= 64'd0;
            board       <= 64'd0;
            board_valid <= 1'b0;
            done        <= 1'b0;
            changed     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            done    <= 1'b0;
            changed <= 1'b0;
            case (state)
                IDLE: begin
                    BlockID <= 4'd0;
                    if (start || auto_en) begin
                        state <= ISSUE;
                        idx   <= 4'd0;
                        busy  <= 1'b1;
                    end
                end

                ISSUE: begin
                    wait_cnt <= 3'(READ_LAT);
                    state    <= (READ_LAT == 0) ? CAPTURE : WAIT;
                end

                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt <= 3'd1) begin
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    shadow <= next_shadow;
                    if (idx == 4'd15) begin
                        board       <= next_shadow;
                        board_valid <= 1'b1;
                        done        <= 1'b1;
                        // board is 0 after reset, so an all-zero first scan
                        // is the only first commit that reports no change.
                        changed     <= (next_shadow != board);
                        state       <= DONE;
                    end else begin
                        idx     <= idx + 4'd1;
                        BlockID <= idx + 4'd1;
                        state   <= ISSUE;
                    end
                end

                DONE: begin
                    idx     <= 4'd0;
                    BlockID <= 4'd0;
                    if (auto_en) begin
                        state <= ISSUE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BOARD_STATS_EN
    logic [3:0] acc_max;
    logic [4:0] acc_empty;
    logic       acc_win;
    logic [3:0] acc_max_next;
    logic [4:0] acc_empty_next;
    logic       acc_win_next;
    logic       scan_begin;

    // A scan starts (idx=0 ISSUE) from IDLE on a request, or from DONE when
    // auto_en keeps the block scanning back-to-back.
    assign scan_begin = ((state == IDLE) && (start || auto_en)) ||
                        ((state == DONE) && auto_en);

    // Running statistics including the tile being captured this cycle.
    always_comb begin
        acc_max_next   = (BlockType > acc_max) ? BlockType : acc_max;
        acc_empty_next = acc_empty + ((BlockType == 4'd0) ? 5'd1 : 5'd0);
        acc_win_next   = acc_win || (int'(BlockType) >= WIN_TYPE);
    end

    // Accumulate per tile; publish on the same edge that commits the board.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_max   <= 4'd0;
            acc_empty <= 5'd0;
            acc_win   <= 1'b0;
            max_type  <= 4'd0;
            empty_cnt <= 5'd0;
            win       <= 1'b0;
        end else if (scan_begin) begin
            acc_max   <= 4'd0;
            acc_empty <= 5'd0;
            acc_win   <= 1'b0;
        end else if (state == CAPTURE) begin
            acc_max   <= acc_max_next;
            acc_empty <= acc_empty_next;
            acc_win   <= acc_win_next;
            if (idx == 4'd15) begin
                max_type  <= acc_max_next;
                empty_cnt <= acc_empty_next;
                win       <= acc_win_next;
            end
        end
    end
`else
    // Statistics disabled: outputs tied low.
    assign max_type  = 4'd0;
    assign empty_cnt = 5'd0;
    assign win       = 1'b0;
`endif

endmodule

// File: tb/tb_board_block_reader.sv
// Self-checking bench for board_block_reader.
// A bus responder serves BlockType from a tile memory with READ_LAT latency
// (garbage before that); a reference model derives the expected committed
// board, change flag, stats and commit cycle from the memory contents, and a
// monitor pops those expectations whenever done pulses.

module tb_board_block_reader;

    localparam int RL       = 1;
    localparam int WIN_T    = 11;
    localparam int TILE_CYC = RL + 2;
    localparam int SCAN_LEN = 16 * TILE_CYC + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic [3:0]  BlockID;
    logic [3:0]  BlockType = 4'd0;
    logic [63:0] board;
    logic        board_valid;
    logic        done;
    logic        changed;
    logic        busy;
    logic [3:0]  max_type;
    logic [4:0]  empty_cnt;
    logic        win;

    board_block_reader #(.READ_LAT(RL), .WIN_TYPE(WIN_T)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .auto_en     (auto_en),
        .BlockID     (BlockID),
        .BlockType   (BlockType),
        .board       (board),
        .board_valid (board_valid),
        .done        (done),
        .changed     (changed),
        .busy        (busy),
        .max_type    (max_type),
        .empty_cnt   (empty_cnt),
        .win         (win)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- bus responder / tile memory ----------------
    logic [3:0] mem [16];
    logic [3:0] last_id = 4'd0;
    int         age = 0;

    always @(negedge clk) begin
        if (BlockID != last_id) begin
            age       <= 0;
            BlockType <= (RL == 0) ? mem[BlockID] : 4'($urandom);
        end else begin
            age       <= (age < 100) ? age + 1 : age;
            BlockType <= (age + 1 >= RL) ? mem[BlockID] : 4'($urandom);
        end
        last_id <= BlockID;
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [63:0] board;
        logic        changed;
        logic [3:0]  max_type;
        logic [4:0]  empty_cnt;
        logic        win;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] prev_board = 64'd0;

    function automatic exp_t model_commit(input int commit_cyc);
        exp_t e;
        int   mx = 0;
        int   ez = 0;
        bit   w  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e.board[4 * i +: 4] = mem[i];
            if (int'(mem[i]) > mx) mx = int'(mem[i]);
            if (mem[i] == 4'd0) ez++;
            if (int'(mem[i]) >= WIN_T) w = 1'b1;
        end
        e.changed = (e.board != prev_board);
`ifdef BOARD_STATS_EN
        e.max_type  = 4'(mx);
        e.empty_cnt = 5'(ez);
        e.win       = w;
`else
        e.max_type  = 4'd0;
        e.empty_cnt = 5'd0;
        e.win       = 1'b0;
`endif
        e.cyc      = commit_cyc;
        prev_board = e.board;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle",  64'(cyc),       64'(e.cyc));
                check("board",       board,          e.board);
                check("changed",     64'(changed),   64'(e.changed));
                check("board_valid", 64'(board_valid), 64'd1);
                check("max_type",    64'(max_type),  64'(e.max_type));
                check("empty_cnt",   64'(empty_cnt), 64'(e.empty_cnt));
                check("win",         64'(win),       64'(e.win));
            end
        end
    end

    // Called at a negedge with the DUT idle: requests one scan, follows the
    // BlockID walk and busy, optionally fires a start that must be ignored.
    task automatic run_scan(input bit extra_start);
        int pulse_at;
        int exp_id;
        sb.push_back(model_commit(cyc + SCAN_LEN));
        pulse_at = extra_start ? int'($urandom_range(3, SCAN_LEN - 4)) : 0;
        start = 1'b1;
        for (int n = 1; n <= SCAN_LEN + 1; n++) begin
            @(negedge clk);
            start = (n == pulse_at);
            if (n < SCAN_LEN)       exp_id = (n - 1) / TILE_CYC;
            else if (n == SCAN_LEN) exp_id = 15;
            else                    exp_id = 0;
            check("block_id", 64'(BlockID), 64'(exp_id));
            check("busy",     64'(busy),    64'(n <= SCAN_LEN));
        end
        start = 1'b0;
        check("scan_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;

        // Reset and a long quiet idle period.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n % 10 == 0) begin
                check("idle_block_id",    64'(BlockID),     64'd0);
                check("idle_busy",        64'(busy),        64'd0);
                check("idle_board_valid", 64'(board_valid), 64'd0);
                check("idle_board",       board,            64'd0);
            end
        end

        // Incrementing pattern: tile i holds i+1 (tile 15 wraps to 0).
        for (int i = 0; i < 16; i++) mem[i] = 4'(i + 1);
        idle(2);
        run_scan(1'b0);
        // Same data again: commit with no change.
        idle(3);
        run_scan(1'b1);

        // Single winning tile.
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        mem[3] = 4'd11;
        idle(2);
        run_scan(1'b0);

        // Randomized boards, sometimes repeated unchanged.
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                for (int i = 0; i < 16; i++)
                    mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            end
            idle(int'($urandom_range(1, 6)));
            run_scan(1'($urandom_range(0, 1)));
        end

        // Continuous mode: three back-to-back scans, auto_en dropped in the third.
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 12));
        idle(2);
        begin
            int c0;
            c0 = cyc;
            for (int s = 1; s <= 3; s++) sb.push_back(model_commit(c0 + s * SCAN_LEN));
            auto_en = 1'b1;
            for (int n = 1; n <= 3 * SCAN_LEN + 10; n++) begin
                @(negedge clk);
                if (n == 2 * SCAN_LEN + 20) auto_en = 1'b0;
                start = (n % 17 == 5) && (n < 3 * SCAN_LEN - 3);
                if (n == 3 * SCAN_LEN + 1 || n == 3 * SCAN_LEN + 10) begin
                    check("auto_end_busy",     64'(busy),    64'd0);
                    check("auto_end_block_id", 64'(BlockID), 64'd0);
                end else if (n % 12 == 0 && n <= 3 * SCAN_LEN) begin
                    check("auto_busy", 64'(busy), 64'd1);
                end
            end
            start = 1'b0;
            check("auto_drained", 64'(sb.size()), 64'd0);
        end

        // Reset in the middle of a scan (tile 7): no commit, outputs cleared at once.
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(1, 15));
        idle(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < SCAN_LEN && !found; n++) begin
            if (BlockID == 4'd7) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_tile7", 64'(found), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_board", board, 64'd0);
        check("rst_small_outputs",
              64'({BlockID, board_valid, done, changed, busy, max_type, empty_cnt, win}),
              64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_board = 64'd0;
        idle(SCAN_LEN + 5);
        check("no_commit_after_reset", 64'(board_valid), 64'd0);
        run_scan(1'b0);

        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_block_reader.md
Name: board_block_reader

Overview:
- Reader side of the MIO_BUS board-tile port: drives BlockID, samples the returned BlockType and assembles a full 16-tile 2048 board snapshot.
- Consumed by the display/VGA path and the game-status logic, so they never address MIO_BUS directly.
- Snapshots are committed atomically: the consumer never sees a half-updated board.

Parameters:
- READ_LAT, 1, cycles from a BlockID change until BlockType is valid (legal range 0..7).
- WIN_TYPE, 11, tile exponent counted as a win (11 = tile 2048).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request for a single scan; ignored while busy
- auto_en  in  1  level; when high, scans back-to-back continuously
- BlockID  out  4  tile index presented to MIO_BUS
- BlockType  in  4  tile exponent returned by MIO_BUS; 0 = empty
- board  out  64  committed snapshot; tile i at bits [4i+3:4i]
- board_valid  out  1  high once the first snapshot is committed; stays high until reset
- done  out  1  one-cycle pulse on each commit
- changed  out  1  one-cycle pulse with done when the new board differs from the previous committed board
- busy  out  1  high from the ISSUE state through the DONE state
- max_type  out  4  largest exponent in the committed board (stats)
- empty_cnt  out  5  number of zero tiles in the committed board, 0..16 (stats)
- win  out  1  any committed tile >= WIN_TYPE (stats)

Behaviour:
- Reset (async, immediate): state=IDLE, idx=0, BlockID=0, wait counter=0, shadow=0, board=0, board_valid=0, done=0, changed=0, busy=0, max_type=0, empty_cnt=0, win=0.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE: BlockID=0. On (start | auto_en) go to ISSUE with idx=0.
- ISSUE: BlockID<=idx, wait counter<=READ_LAT. Go to WAIT, or directly to CAPTURE when READ_LAT=0.
- WAIT: decrement the counter; go to CAPTURE when it reaches 1.
- CAPTURE: shadow[idx]<=BlockType; accumulate the running max, zero count and win flag.
  - idx==15 -> DONE.
  - Otherwise idx<=idx+1 -> ISSUE.
- Per-tile cost is READ_LAT+2 cycles. Full scan = 16*(READ_LAT+2)+1 cycles including DONE; 49 cycles at the default.
- DONE (1 cycle), all registered updates in this cycle:
  - board<=shadow, done=1, board_valid<=1.
  - changed=1 if shadow!=previous board. The very first commit after reset counts as changed unless the shadow is all zero.
  - Stats outputs take the accumulated values.
  - Next state: ISSUE with idx=0 if auto_en, otherwise IDLE.
- BlockID stays stable for the whole ISSUE..CAPTURE window of a tile. It changes only on the ISSUE edge.
- start pulses arriving in any non-IDLE state are dropped; there is no queuing.
- auto_en deasserted mid-scan: the current scan finishes and commits, then the block returns to IDLE.
- start and auto_en both high in IDLE: one scan begins. Behaviour afterwards follows auto_en.
- Reset mid-scan: the partial shadow is discarded and board returns to 0. No done pulse is generated.
- BlockType is sampled only in CAPTURE; values in other states are don't-care.
- The running accumulators clear on entry to ISSUE with idx=0, never between tiles.
- empty_cnt is 5 bits so that 16 is representable.

Optional Feature:
- Macro: BOARD_STATS_EN.
- Defined: max_type, empty_cnt and win are computed as described and update in the DONE cycle.
- Undefined: the accumulators are not built; max_type=0, empty_cnt=0, win=0 at all times.
- board, done, changed and board_valid are unaffected by the macro.

Test Plan:
- Reset then idle, auto_en=0, no start for 100 cycles -> BlockID=0, busy=0, board_valid=0, done never pulses.
- Model responds BlockType=ID+1 after READ_LAT=1; start pulse at cycle 10 -> BlockID steps 0..15 every 3 cycles; done pulses at cycle 10+49; board=64'h0_F_E_D_C_B_A_9_8_7_6_5_4_3_2_1 with nibble 15 = 0 due to 4-bit wrap; changed=1; with BOARD_STATS_EN: max_type=15, empty_cnt=1, win=1.
- Repeat the same scan with an unchanged model -> done=1 and changed=0; board unchanged.
- Set the model's tile 3 to 11, all others 0; run a scan -> board[15:12]=4'hB, max_type=11, empty_cnt=15, win=1; without the macro, all three stats read 0.
- auto_en=1 for 3 scans, then drop it during scan 3 -> exactly 3 done pulses spaced 49 cycles apart; after the last, state is IDLE and busy=0; extra start pulses during the scans produce no additional scan.
- Assert rst for 2 cycles at tile 7 of a scan -> all outputs are 0 immediately (async, no clock edge needed); no done pulse; a subsequent start yields a full 49-cycle scan.
